// File: rtl/gat_feat_readback.sv
// Streams the final GAT feature words from feature BRAM port B out as AXI-Stream beats.
// Optional FEAT_RD_PACK_EN packs four 8-bit features per beat instead of sign-extending one.
module gat_feat_readback #(
  parameter int DATA_WIDTH         = 8,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2,
  parameter int FIFO_DEPTH         = BRAM_RD_LATENCY + 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_start,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [31:0]                   feat_bram_dout,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LAT   = BRAM_RD_LATENCY;
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LAST_IDX   = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [CNT_W:0]                CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]              LAST_PTR   = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [NEW_FEATURE_ADDR_W-1:0] addr_idx_q, addr_idx_d;
  logic [CNT_W-1:0]              fifo_cnt_q, fifo_cnt_d, inflight_q, inflight_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0]                pipe_vld_q, pipe_vld_d, pipe_last_q, pipe_last_d;
  logic [32:0]                   fifo_mem_q [FIFO_DEPTH];
  logic [32:0]                   push_word;
  logic                          issue, issue_last, is_last_addr, credit_ok;
  logic                          inflight_inc, push, pop;
  logic                          unused_dout_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign unused_dout_bits = ^feat_bram_dout[31:DATA_WIDTH];
  assign is_last_addr     = (addr_idx_q == LAST_IDX);
  // Credit covers both queued entries and reads whose data is still in the BRAM pipe.
  assign credit_ok        = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < CREDIT_MAX;
  assign issue_last       = issue && is_last_addr;

`ifdef FEAT_RD_PACK_EN
  logic [1:0]  issue_lane_q, issue_lane_d, pack_lane_q, pack_lane_d;
  logic [31:0] pack_data_q, pack_data_d, lane_word;

  // Only the first word of a group needs a credit; the group's beat is reserved then.
  assign issue        = (state_q == S_READ) && ((issue_lane_q != 2'd0) || credit_ok);
  assign inflight_inc = issue && (issue_lane_q == 2'd0);

  always_comb begin
    issue_lane_d = issue_lane_q;
    if (issue) issue_lane_d = issue_last ? 2'd0 : issue_lane_q + 2'd1;
    lane_word   = pack_data_q | ({24'd0, feat_bram_dout[7:0]} << {pack_lane_q, 3'b000});
    push        = pipe_vld_q[LAT-1] && ((pack_lane_q == 2'd3) || pipe_last_q[LAT-1]);
    push_word   = {pipe_last_q[LAT-1], lane_word};
    pack_data_d = pack_data_q;
    pack_lane_d = pack_lane_q;
    if (pipe_vld_q[LAT-1]) begin
      pack_data_d = push ? 32'd0 : lane_word;
      pack_lane_d = push ? 2'd0 : pack_lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_lane_q <= 2'd0;
      pack_lane_q  <= 2'd0;
      pack_data_q  <= 32'd0;
    end else begin
      issue_lane_q <= issue_lane_d;
      pack_lane_q  <= pack_lane_d;
      pack_data_q  <= pack_data_d;
    end
  end
`else
  assign issue        = (state_q == S_READ) && credit_ok;
  assign inflight_inc = issue;
  assign push         = pipe_vld_q[LAT-1];
  assign push_word    = {pipe_last_q[LAT-1],
                         {(32-DATA_WIDTH){feat_bram_dout[DATA_WIDTH-1]}},
                         feat_bram_dout[DATA_WIDTH-1:0]};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_vld_d[gi]  = issue;
        assign pipe_last_d[gi] = issue_last;
      end else begin : g_tail
        assign pipe_vld_d[gi]  = pipe_vld_q[gi-1];
        assign pipe_last_d[gi] = pipe_last_q[gi-1];
      end
    end
  endgenerate

  assign m_axis_tvalid   = (fifo_cnt_q != '0);
  assign pop             = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata    = m_axis_tvalid ? fifo_mem_q[rd_ptr_q][31:0] : 32'd0;
  assign m_axis_tlast    = m_axis_tvalid && fifo_mem_q[rd_ptr_q][32];
  assign feat_bram_addrb = {addr_idx_q, 2'b00};

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    inflight_d = inflight_q;
    if (inflight_inc && !push)      inflight_d = inflight_q + 1'b1;
    else if (!inflight_inc && push) inflight_d = inflight_q - 1'b1;
    addr_idx_d = addr_idx_q;
    if ((state_q == S_IDLE) && rd_start) addr_idx_d = '0;
    else if (issue && !is_last_addr)     addr_idx_d = addr_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_idx_q  <= '0;
      fifo_cnt_q  <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_idx_q  <= addr_idx_d;
      fifo_cnt_q  <= fifo_cnt_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= push_word;
  end

  // Drain exit looks at next-cycle occupancy so done lands right after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (rd_start) state_d = gat_ready ? S_READ : S_WAIT_RDY;
      S_WAIT_RDY: if (gat_ready) state_d = S_READ;
      S_READ:     if (issue_last) state_d = S_DRAIN;
      S_DRAIN:    if ((fifo_cnt_d == '0) && (inflight_d == '0)) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_WAIT_RDY) || (state_q == S_READ) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_gat_feat_readback.sv
// Directed bench for gat_feat_readback with a BRAM model and a beat-list scoreboard (depth 8, latency 2).
module tb_gat_feat_readback;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst_n = 1'b0, rd_start = 1'b0, gat_ready = 1'b0, m_axis_tready = 1'b0;
  logic [4:0]  addrb;
  logic [31:0] dout, tdata;
  logic        tvalid, tlast, busy, done;

  int total = 0, bad = 0, beat_cnt = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] rd1 = '0, rd2 = '0;
  logic [31:0] exp_data [$];
  logic        exp_last [$];
  logic        prev_hold = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] lit [8];

  always #5 clk = ~clk;

  gat_feat_readback #(
    .NUM_SUBGRAPHS(2), .NUM_FEATURE_OUT(4), .BRAM_RD_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .gat_ready(gat_ready),
    .feat_bram_addrb(addrb), .feat_bram_dout(dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(tlast), .busy(busy), .done(done)
  );

  // Two-cycle read latency BRAM
  always @(posedge clk) begin
    rd1 <= mem[addrb[4:2]];
    rd2 <= rd1;
  end
  assign dout = rd2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic load_mem(input int mode);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (mode == 0) ? 32'(i - 4) : (mode == 1) ? 32'h1234_5680 + 32'(i) : 32'(i + 1);
  endtask

  task automatic build_exp();
    logic [31:0] w;
    exp_data.delete();
    exp_last.delete();
`ifdef FEAT_RD_PACK_EN
    for (int g = 0; g < (DEPTH + 3) / 4; g++) begin
      w = '0;
      for (int k = 0; k < 4; k++)
        if (4 * g + k < DEPTH) w[8*k +: 8] = mem[4*g+k][7:0];
      exp_data.push_back(w);
      exp_last.push_back(g == (DEPTH + 3) / 4 - 1);
    end
`else
    for (int i = 0; i < DEPTH; i++) begin
      w = 32'($signed(mem[i][7:0]));
      exp_data.push_back(w);
      exp_last.push_back(i == DEPTH - 1);
    end
`endif
  endtask

  // Scoreboard: every handshake against the model list, plus hold-stability under backpressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_hold) begin
        chk("hold_valid", 32'(tvalid), 32'd1);
        chk("hold_data", tdata, prev_data);
        chk("hold_last", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && m_axis_tready) begin
        chk("beat_expected", 32'(exp_data.size() != 0), 32'd1);
        if (exp_data.size() != 0) begin
          chk("beat_data", tdata, exp_data.pop_front());
          chk("beat_last", 32'(tlast), 32'(exp_last.pop_front()));
        end
        beat_cnt++;
      end
      prev_hold = tvalid && !m_axis_tready;
      prev_data = tdata;
      prev_last = tlast;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic check_idle_outputs(input string name);
    chk({name, "_addrb"}, 32'(addrb), 32'd0);
    chk({name, "_tvalid"}, 32'(tvalid), 32'd0);
    chk({name, "_tlast"}, 32'(tlast), 32'd0);
    chk({name, "_tdata"}, tdata, 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 rd_start = 1'b1;
    @(posedge clk); #1 rd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, input string name);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        if (rnd) m_axis_tready = ($urandom_range(0, 9) < 3);
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_all_beats"}, 32'(exp_data.size()), 32'd0);
    $display("txn %s: readback finished, beats=%0d", name, beat_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lit[0] = 32'hFFFF_FFFC; lit[1] = 32'hFFFF_FFFD; lit[2] = 32'hFFFF_FFFE; lit[3] = 32'hFFFF_FFFF;
    lit[4] = 32'h0; lit[5] = 32'h1; lit[6] = 32'h2; lit[7] = 32'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Test 1: back-to-back readback, cycle-exact timing
`ifdef FEAT_RD_PACK_EN
    load_mem(2);
    build_exp();
    chk("model_pack_b0", exp_data[0], 32'h0403_0201);
    chk("model_pack_b1", exp_data[1], 32'h0807_0605);
`else
    load_mem(0);
    build_exp();
    chk("model_b0", exp_data[0], 32'hFFFF_FFFC);
    chk("model_b7", exp_data[7], 32'h3);
    chk("model_last7", 32'(exp_last[7]), 32'd1);
`endif
    gat_ready = 1'b1;
    m_axis_tready = 1'b1;
    beat_cnt = 0;
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("t1_addrb_c%0d", k), 32'(addrb), (k - 1 < 8) ? 32'((k - 1) * 4) : 32'd28);
      chk($sformatf("t1_busy_c%0d", k), 32'(busy), 32'(k <= 11));
      chk($sformatf("t1_done_c%0d", k), 32'(done), 32'(k == 12));
`ifndef FEAT_RD_PACK_EN
      chk($sformatf("t1_tvalid_c%0d", k), 32'(tvalid), 32'(k >= 4 && k <= 11));
      chk($sformatf("t1_tlast_c%0d", k), 32'(tlast), 32'(k == 11));
      if (k >= 4 && k <= 11) chk($sformatf("t1_tdata_c%0d", k), tdata, lit[k-4]);
`endif
    end
    chk("t1_all_beats", 32'(exp_data.size()), 32'd0);
    $display("txn t1: back-to-back readback, beats=%0d", beat_cnt);

    // Test 2: start while core not ready
    build_exp();
    beat_cnt = 0;
    gat_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t2_addrb_wait", 32'(addrb), 32'd0);
      chk("t2_tvalid_wait", 32'(tvalid), 32'd0);
      chk("t2_busy_wait", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 gat_ready = 1'b1;
    wait_done(60, 1'b0, "t2");

    // Test 3: sink stalled, credit limits issues
    build_exp();
    beat_cnt = 0;
    m_axis_tready = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
`ifndef FEAT_RD_PACK_EN
    chk("t3_addrb_stall", 32'(addrb), 32'd16);
    chk("t3_tdata_head", tdata, 32'hFFFF_FFFC);
`endif
    chk("t3_tvalid", 32'(tvalid), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 m_axis_tready = 1'b1;
    wait_done(60, 1'b0, "t3");

    // Test 4: random backpressure
    load_mem(1);
    build_exp();
`ifndef FEAT_RD_PACK_EN
    chk("model_r_last", exp_data[7], 32'hFFFF_FF87);
`endif
    beat_cnt = 0;
    m_axis_tready = 1'b0;
    pulse_start();
    wait_done(400, 1'b1, "t4");
    m_axis_tready = 1'b1;

    // Test 5: reset mid-readback, then restart
    load_mem(0);
    build_exp();
    beat_cnt = 0;
    pulse_start();
    for (int n = 0; n < 40 && beat_cnt < 3; n++) @(negedge clk);
    chk("t5_three_beats", 32'(beat_cnt >= 3), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle_outputs("t5_abort");
    $display("txn t5: aborted after %0d beats", beat_cnt);
    @(posedge clk); #1 rst_n = 1'b1;
    build_exp();
    beat_cnt = 0;
    pulse_start();
    @(negedge clk);
    chk("t5_restart_addr0", 32'(addrb), 32'd0);
    @(negedge clk);
    chk("t5_restart_addr1", 32'(addrb), 32'd4);
    wait_done(60, 1'b0, "t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
